bcd_seq_divider: RTL and testbench
==================================

BCD_SEQ_DIVIDER -- requirements
Module: bcd_seq_divider

Interface
REQ-001 SHALL have parameter NDIG, default 2: BCD digits per operand and per result field; legal values 1..4.
REQ-002 SHALL use a derived constant W = 4*NDIG as the binary datapath width.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port a_bcd, input, 4*NDIG bits: dividend, packed BCD, most significant digit in the top nibble.
REQ-007 SHALL have port b_bcd, input, 4*NDIG bits: divisor, packed BCD, same packing as a_bcd.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that results are valid.
REQ-010 SHALL have port q_bcd, output, 4*NDIG bits: quotient, packed BCD.
REQ-011 SHALL have port r_bcd, output, 4*NDIG bits: remainder, packed BCD.
REQ-012 SHALL have port div_zero, output, 1 bit: the last operation had a divisor of zero.
REQ-013 SHALL have port in_err, output, 1 bit: the last operation had an operand nibble greater than 9.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, DIV, CVT and DONE; busy = 1 in CONV, DIV and CVT only.
REQ-015 IDLE: start=1 at edge E0 SHALL capture a_bcd and b_bcd into internal registers and enter CONV; inputs SHALL be ignored after E0.
REQ-016 CONV SHALL take NDIG cycles, converting both operands to binary with one digit per cycle (acc = acc*10 + digit, MSD first).
REQ-017 CONV SHALL check every captured nibble; any nibble > 9 SHALL set the error flag.
REQ-018 CONV exit: if the error flag is set, or the divisor equals 0, the FSM SHALL go directly to DONE; otherwise it SHALL go to DIV.
REQ-019 DIV SHALL be a restoring shift-subtract divider producing one quotient bit per cycle, exactly W cycles, with a W+1-bit partial remainder.
REQ-020 CVT SHALL run double-dabble on quotient and remainder in parallel: exactly W shift cycles, add-3 to any nibble >= 5 before each shift.
REQ-021 DONE SHALL last 1 cycle: register q_bcd, r_bcd, div_zero and in_err, pulse done=1, then return to IDLE.
REQ-022 Latency SHALL be counted from E0 to the edge at which done rises: NDIG+2W+1 cycles for a normal operation, NDIG+1 cycles for a zero divisor or invalid input (NDIG=2: 19 and 3 cycles).
REQ-023 Zero divisor SHALL produce q_bcd=0, r_bcd=0, div_zero=1, in_err=0.
REQ-024 Invalid input SHALL produce q_bcd=0, r_bcd=0, in_err=1, div_zero=0; in_err SHALL take priority over div_zero.
REQ-025 A zero dividend with a nonzero divisor SHALL be a normal operation giving q=0 and r=0.
REQ-026 start asserted while busy or in DONE SHALL be ignored, with no queuing.
REQ-027 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE.
REQ-028 q_bcd, r_bcd, div_zero and in_err SHALL hold their values between done pulses, changing only in DONE.
REQ-029 Results SHALL satisfy a = q*b + r with r < b for every legal operand pair.

Reset
REQ-030 reset=1 SHALL force IDLE immediately, independent of clk.
REQ-031 Reset values: busy=0, done=0, q_bcd=0, r_bcd=0, div_zero=0, in_err=0; all internal registers cleared.
REQ-032 reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset releases SHALL be accepted normally.

Verification
REQ-033 NDIG=2, a=84, b=12, start pulse -> done rises 19 cycles later; q=07, r=00, div_zero=0, in_err=0.
REQ-034 NDIG=2, a=99, b=10 -> q=09, r=09; then a=00, b=07 -> q=00, r=00.
REQ-035 NDIG=2, a=05, b=00 -> done rises after 3 cycles; q=00, r=00, div_zero=1; then a=0xA3 (invalid nibble), b=02 -> in_err=1, div_zero=0.
REQ-036 NDIG=2, a=84, b=12; a second start with a=50, b=05 during DIV -> results q=07, r=00; exactly one done pulse; busy stays high continuously.
REQ-037 Reset asserted 5 cycles into an operation -> all outputs 0 asynchronously, no done pulse; a following 63/08 -> q=07, r=07.
REQ-038 NDIG=3, a=999, b=001 -> q=999, r=000 with latency 28; plus a random sweep of legal operand pairs checked against REQ-029.

Source files
------------

// File: rtl/bcd_seq_divider.sv
// Sequential BCD divider: converts packed-BCD operands to binary, divides with a
// restoring shift-subtract loop, then converts quotient and remainder back to BCD.
module bcd_seq_divider #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4*NDIG-1:0] a_bcd,
    input  logic [4*NDIG-1:0] b_bcd,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] q_bcd,
    output logic [4*NDIG-1:0] r_bcd,
    output logic              div_zero,
    output logic              in_err
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(NDIG - 1);
    localparam logic [CW-1:0] LOOP_LAST = CW'(W - 1);
    localparam logic [W-1:0]  TEN       = W'(10);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_DIV, S_CVT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    // quo_q holds the binary dividend, is shifted into quotient bits during DIV,
    // and is shifted out MSB-first into the BCD converter during CVT.
    logic [W-1:0]   quo_q, quo_d, div_q, div_d, rem_q, rem_d;
    logic [W-1:0]   qacc_q, qacc_d, racc_q, racc_d;
    logic           err_q, err_d, dz_q, dz_d;
    logic           done_q, done_d, div_zero_q, div_zero_d, in_err_q, in_err_d;
    logic [W-1:0]   q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;

    logic [3:0]     a_dig, b_dig;
    logic [W:0]     trial, diff;
    logic [W-1:0]   q_adj, r_adj;

    function automatic logic [W-1:0] add3(input logic [W-1:0] v);
        logic [W-1:0] o;
        o = v;
        for (int i = 0; i < NDIG; i++)
            if (o[4*i +: 4] >= 4'd5) o[4*i +: 4] = o[4*i +: 4] + 4'd3;
        return o;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        quo_d      = quo_q;
        div_d      = div_q;
        rem_d      = rem_q;
        qacc_d     = qacc_q;
        racc_d     = racc_q;
        err_d      = err_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        in_err_d   = in_err_q;
        q_bcd_d    = q_bcd_q;
        r_bcd_d    = r_bcd_q;
        a_dig      = a_sh_q[W-1 -: 4];
        b_dig      = b_sh_q[W-1 -: 4];
        trial      = {rem_q, quo_q[W-1]};
        diff       = trial - {1'b0, div_q};
        q_adj      = add3(qacc_q);
        r_adj      = add3(racc_q);

        unique case (state_q)
            S_IDLE: if (start) begin
                a_sh_d  = a_bcd;
                b_sh_d  = b_bcd;
                quo_d   = '0;
                div_d   = '0;
                err_d   = 1'b0;
                dz_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                quo_d  = quo_q * TEN + W'(a_dig);
                div_d  = div_q * TEN + W'(b_dig);
                err_d  = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
                a_sh_d = a_sh_q << 4;
                b_sh_d = b_sh_q << 4;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CONV_LAST) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    dz_d    = (div_d == '0);
                    state_d = (err_d || dz_d) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                // A non-negative trial difference means the divisor fits: keep it.
                if (!diff[W]) begin
                    rem_d = diff[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = trial[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LOOP_LAST) begin
                    cnt_d   = '0;
                    qacc_d  = '0;
                    racc_d  = '0;
                    state_d = S_CVT;
                end
            end
            S_CVT: begin
                qacc_d = {q_adj[W-2:0], quo_q[W-1]};
                racc_d = {r_adj[W-2:0], rem_q[W-1]};
                quo_d  = {quo_q[W-2:0], 1'b0};
                rem_d  = {rem_q[W-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LOOP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                in_err_d   = err_q;
                div_zero_d = dz_q & ~err_q;
                q_bcd_d    = (err_q || dz_q) ? '0 : qacc_q;
                r_bcd_d    = (err_q || dz_q) ? '0 : racc_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the datapath is plain flops rather than a memory array, so it is
            // all cleared here; nothing can leak from an aborted operation.
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            qacc_q     <= '0;
            racc_q     <= '0;
            err_q      <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            in_err_q   <= 1'b0;
            q_bcd_q    <= '0;
            r_bcd_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            qacc_q     <= qacc_d;
            racc_q     <= racc_d;
            err_q      <= err_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            in_err_q   <= in_err_d;
            q_bcd_q    <= q_bcd_d;
            r_bcd_q    <= r_bcd_d;
        end
    end

    assign busy     = (state_q == S_CONV) || (state_q == S_DIV) || (state_q == S_CVT);
    assign done     = done_q;
    assign q_bcd    = q_bcd_q;
    assign r_bcd    = r_bcd_q;
    assign div_zero = div_zero_q;
    assign in_err   = in_err_q;
endmodule

// File: tb/tb_bcd_seq_divider.sv
// Scoreboard bench for bcd_seq_divider: NDIG=2 and NDIG=3 instances, directed
// vectors with hand-computed results plus a random sweep checked by integer math.
module tb_bcd_seq_divider;
    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ie;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start2, busy2, done2, dz2, ie2;
    logic [7:0] a2, b2, q2, r2;
    logic        start3, busy3, done3, dz3, ie3;
    logic [11:0] a3, b3, q3, r3;

    bcd_seq_divider #(.NDIG(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a_bcd(a2), .b_bcd(b2),
        .busy(busy2), .done(done2), .q_bcd(q2), .r_bcd(r2),
        .div_zero(dz2), .in_err(ie2)
    );

    bcd_seq_divider #(.NDIG(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .a_bcd(a3), .b_bcd(b3),
        .busy(busy3), .done(done3), .q_bcd(q3), .r_bcd(r3),
        .div_zero(dz3), .in_err(ie3)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    int   done2_cnt = 0;
    exp_t sb2[$];
    exp_t sb3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] o;
        o[3:0]   = 4'(v % 10);
        o[7:4]   = 4'((v / 10) % 10);
        o[11:8]  = 4'((v / 100) % 10);
        o[15:12] = 4'((v / 1000) % 10);
        return o;
    endfunction

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            done2_cnt++;
            if (sb2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done2: done=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = sb2.pop_front();
                check("q2", 32'(q2), 32'(e.q[7:0]));
                check("r2", 32'(r2), 32'(e.r[7:0]));
                check("div_zero2", 32'(dz2), 32'(e.dz));
                check("in_err2", 32'(ie2), 32'(e.ie));
                check("latency2", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (done3 === 1'b1) begin
            if (sb3.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done3: done=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = sb3.pop_front();
                check("q3", 32'(q3), 32'(e.q[11:0]));
                check("r3", 32'(r3), 32'(e.r[11:0]));
                check("div_zero3", 32'(dz3), 32'(e.dz));
                check("in_err3", 32'(ie3), 32'(e.ie));
                check("latency3", cyc, e.due);
            end
        end
    end

    task automatic issue2(input logic [15:0] a, b, q, r, input logic dz, ie, input int unsigned lat);
        exp_t e;
        @(posedge clk);
        #1;
        a2 = a[7:0];
        b2 = b[7:0];
        start2 = 1'b1;
        e.q = q; e.r = r; e.dz = dz; e.ie = ie; e.due = cyc + 1 + lat;
        sb2.push_back(e);
        @(posedge clk);
        #1;
        start2 = 1'b0;
        a2 = 8'h55;
        b2 = 8'h00;
    endtask

    task automatic issue3(input logic [15:0] a, b, q, r, input logic dz, ie, input int unsigned lat);
        exp_t e;
        @(posedge clk);
        #1;
        a3 = a[11:0];
        b3 = b[11:0];
        start3 = 1'b1;
        e.q = q; e.r = r; e.dz = dz; e.ie = ie; e.due = cyc + 1 + lat;
        sb3.push_back(e);
        @(posedge clk);
        #1;
        start3 = 1'b0;
        a3 = 12'h555;
        b3 = 12'h000;
    endtask

    task automatic wait2();
        int n = 0;
        while (sb2.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb2.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout2: %0d results outstanding, required 0", sb2.size());
            sb2.delete();
        end
    endtask

    task automatic wait3();
        int n = 0;
        while (sb3.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb3.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout3: %0d results outstanding, required 0", sb3.size());
            sb3.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, low;
        int unsigned ra, rb;
        reset = 1'b1;
        start2 = 1'b0; a2 = '0; b2 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_q", 32'(q2), 32'd0);
        check("rst_r", 32'(r2), 32'd0);
        check("rst_dz", 32'(dz2), 32'd0);
        check("rst_ie", 32'(ie2), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue2(16'h84, 16'h12, 16'h07, 16'h00, 1'b0, 1'b0, 19); wait2();
        repeat (5) @(posedge clk);
        #1;
        check("hold_q", 32'(q2), 32'h07);
        check("hold_r", 32'(r2), 32'h00);

        issue2(16'h99, 16'h10, 16'h09, 16'h09, 1'b0, 1'b0, 19); wait2();
        issue2(16'h00, 16'h07, 16'h00, 16'h00, 1'b0, 1'b0, 19); wait2();
        issue2(16'h05, 16'h00, 16'h00, 16'h00, 1'b1, 1'b0, 3);  wait2();
        issue2(16'hA3, 16'h02, 16'h00, 16'h00, 1'b0, 1'b1, 3);  wait2();
        issue2(16'hA3, 16'h00, 16'h00, 16'h00, 1'b0, 1'b1, 3);  wait2();
        issue2(16'h45, 16'h1F, 16'h00, 16'h00, 1'b0, 1'b1, 3);  wait2();
        issue2(16'h01, 16'h99, 16'h00, 16'h01, 1'b0, 1'b0, 19); wait2();
        issue2(16'h99, 16'h01, 16'h99, 16'h00, 1'b0, 1'b0, 19); wait2();

        // Second start during DIV must be ignored; busy must not drop before DONE.
        base = done2_cnt;
        low = 0;
        issue2(16'h84, 16'h12, 16'h07, 16'h00, 1'b0, 1'b0, 19);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (busy2 !== 1'b1) low++;
            if (i == 8) begin
                a2 = 8'h50; b2 = 8'h05; start2 = 1'b1;
                check("old_q_kept", 32'(q2), 32'h99);
            end
            if (i == 9) start2 = 1'b0;
        end
        check("busy_continuous", 32'(low), 32'd0);
        wait2();
        repeat (30) @(posedge clk);
        check("one_done_pulse", 32'(done2_cnt - base), 32'd1);

        // start held high: a new operation begins on the IDLE cycle after DONE.
        begin
            exp_t e;
            @(posedge clk);
            #1;
            a2 = 8'h84; b2 = 8'h12; start2 = 1'b1;
            e.q = 16'h07; e.r = 16'h00; e.dz = 1'b0; e.ie = 1'b0; e.due = cyc + 1 + 19;
            sb2.push_back(e);
            e.due = e.due + 1 + 19;
            sb2.push_back(e);
            repeat (25) @(posedge clk);
            #1 start2 = 1'b0;
            wait2();
        end

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #1;
        a2 = 8'h84; b2 = 8'h12; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy2), 32'd0);
        check("abort_done", 32'(done2), 32'd0);
        check("abort_q", 32'(q2), 32'd0);
        check("abort_r", 32'(r2), 32'd0);
        check("abort_dz", 32'(dz2), 32'd0);
        check("abort_ie", 32'(ie2), 32'd0);
        base = done2_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (25) @(posedge clk);
        check("no_done_after_abort", 32'(done2_cnt - base), 32'd0);
        issue2(16'h63, 16'h08, 16'h07, 16'h07, 1'b0, 1'b0, 19); wait2();

        for (int i = 0; i < 10; i++) begin
            ra = $urandom_range(0, 99);
            rb = $urandom_range(1, 99);
            issue2(to_bcd(ra), to_bcd(rb), to_bcd(ra / rb), to_bcd(ra % rb), 1'b0, 1'b0, 19);
            wait2();
        end

        issue3(16'h999, 16'h001, 16'h999, 16'h000, 1'b0, 1'b0, 28); wait3();
        issue3(16'h123, 16'h000, 16'h000, 16'h000, 1'b1, 1'b0, 4);  wait3();
        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(0, 999);
            rb = $urandom_range(1, 999);
            issue3(to_bcd(ra), to_bcd(rb), to_bcd(ra / rb), to_bcd(ra % rb), 1'b0, 1'b0, 28);
            wait3();
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
